mru_cmd_issuer: RTL

//   Upstream command front-end for the 8-entry MRU buffer. Accepts set/get requests on a

---
 rtl/mru_cmd_issuer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mru_cmd_issuer.sv
// Command front-end for the MRU buffer: queues set/get requests, issues them as
// single-cycle MRU strobes, and returns get results in order on a response port.
module mru_cmd_issuer #(
    parameter int WIDTH      = 16,
    parameter int BUF_SIZE   = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int GET_LAT    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic                          cmd_op_i,
    input  logic [WIDTH-1:0]              cmd_data_i,
    output logic                          mru_en_o,
    output logic                          mru_set_o,
    output logic                          mru_get_o,
    output logic [WIDTH-1:0]              mru_data_o,
    input  logic [WIDTH-1:0]              mru_data_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [WIDTH-1:0]              rsp_data_o,
    output logic                          rsp_err_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          busy_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = 2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state, state_next;
    logic               op_mem   [FIFO_DEPTH];
    logic [WIDTH-1:0]   data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [LVL_W-1:0]   level;
    logic [CNT_W-1:0]   lat_cnt;
    logic               push, pop;
    logic               head_op, head_bad;
    logic [WIDTH-1:0]   head_data;
    logic               en_d, set_d, get_d, err_d;
    logic [WIDTH-1:0]   mru_data_d, rsp_data_d;

    assign cmd_ready_o  = (level != LVL_W'(FIFO_DEPTH));
    assign push         = cmd_valid_i && cmd_ready_o;
    assign pop          = (state == IDLE) && (level != '0);
    assign head_op      = op_mem[rd_ptr];
    assign head_data    = data_mem[rd_ptr];
    // Out-of-range check uses every bit of the index, not just the low address bits.
    assign head_bad     = head_op && (head_data >= WIDTH'(BUF_SIZE));
    assign fifo_level_o = level;
    assign rsp_valid_o  = (state == RESP);
    assign busy_o       = (state != IDLE) || (level != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr]   <= cmd_op_i;
            data_mem[wr_ptr] <= cmd_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            lat_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == ISSUE)     lat_cnt <= CNT_W'(GET_LAT);
            else if (state == WAIT) lat_cnt <= lat_cnt - CNT_W'(1);
        end
    end

    // mru_get_o is high exactly during ISSUE of a get, so it tells ISSUE where to go.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (pop) state_next = head_bad ? RESP : ISSUE;
            ISSUE: state_next = mru_get_o ? WAIT : IDLE;
            WAIT:  if (lat_cnt == CNT_W'(1)) state_next = RESP;
            RESP:  if (rsp_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        en_d       = 1'b0;
        set_d      = 1'b0;
        get_d      = 1'b0;
        mru_data_d = mru_data_o;
        rsp_data_d = rsp_data_o;
        err_d      = rsp_err_o;
        if (pop) begin
            if (head_bad) begin
                rsp_data_d = '0;
                err_d      = 1'b1;
            end else begin
                en_d       = 1'b1;
                set_d      = !head_op;
                get_d      = head_op;
                mru_data_d = head_data;
            end
        end
        if ((state == WAIT) && (lat_cnt == CNT_W'(1))) begin
            rsp_data_d = mru_data_i;
            err_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mru_en_o   <= 1'b0;
            mru_set_o  <= 1'b0;
            mru_get_o  <= 1'b0;
            mru_data_o <= '0;
            rsp_data_o <= '0;
            rsp_err_o  <= 1'b0;
        end else begin
            mru_en_o   <= en_d;
            mru_set_o  <= set_d;
            mru_get_o  <= get_d;
            mru_data_o <= mru_data_d;
            rsp_data_o <= rsp_data_d;
            rsp_err_o  <= err_d;
        end
    end

endmodule
